// File: rtl/dual_issue_sequencer.sv
// Two-wide issue sequencer: buffers one fetched pair and issues it either as a
// pair in one cycle or split over two cycles, with flush, backpressure and counters.
module dual_issue_sequencer #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_ins1,
    input  logic [31:0]      fetch_ins2,
    input  logic             pair_ok,
    input  logic             issue_ready,
    input  logic             flush,
    output logic             fetch_ready,
    output logic             slot0_valid,
    output logic [31:0]      slot0_ins,
    output logic             slot1_valid,
    output logic [31:0]      slot1_ins,
    output logic [1:0]       pc_adv,
    output logic [CNT_W-1:0] pair_cnt,
    output logic [CNT_W-1:0] single_cnt
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;

    logic [1:0]       state_r;
    logic [31:0]      buf1_r;
    logic [31:0]      buf2_r;
    logic             buf_ok_r;
    logic [CNT_W-1:0] pair_cnt_r;
    logic [CNT_W-1:0] single_cnt_r;

    logic [1:0]  next_state_s;
    logic        capture_s;
    logic        pair_inc_s;
    logic        single_inc_s;
    logic        fire_s;
    logic        fetch_ready_s;
    logic        slot0_valid_s;
    logic [31:0] slot0_ins_s;
    logic        slot1_valid_s;
    logic [31:0] slot1_ins_s;
    logic [1:0]  pc_adv_s;

    assign fire_s = issue_ready & ~flush;

    // Next-state, slot presentation, capture and counter-increment decode.
    always_comb begin
        next_state_s  = state_r;
        capture_s     = 1'b0;
        pair_inc_s    = 1'b0;
        single_inc_s  = 1'b0;
        fetch_ready_s = 1'b0;
        slot0_valid_s = 1'b0;
        slot0_ins_s   = NOP;
        slot1_valid_s = 1'b0;
        slot1_ins_s   = NOP;
        pc_adv_s      = 2'd0;
        case (state_r)
            ST_EMPTY: begin
                fetch_ready_s = ~flush;
                if (fetch_valid && !flush) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_FULL;
                end else begin
                    next_state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                slot0_valid_s = 1'b1;
                slot0_ins_s   = buf1_r;
                slot1_valid_s = buf_ok_r;
                slot1_ins_s   = buf_ok_r ? buf2_r : NOP;
                if (fire_s && buf_ok_r) begin
                    pc_adv_s      = 2'd2;
                    pair_inc_s    = 1'b1;
                    fetch_ready_s = 1'b1;
                    // Bypass: refill in the same cycle keeps dual issue back to back.
                    if (fetch_valid) begin
                        capture_s    = 1'b1;
                        next_state_s = ST_FULL;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end else if (fire_s) begin
                    pc_adv_s     = 2'd1;
                    single_inc_s = 1'b1;
                    next_state_s = ST_SECOND;
                end else begin
                    next_state_s = ST_FULL;
                end
            end
            ST_SECOND: begin
                slot0_valid_s = 1'b1;
                slot0_ins_s   = buf2_r;
                if (fire_s) begin
                    pc_adv_s      = 2'd1;
                    single_inc_s  = 1'b1;
                    fetch_ready_s = 1'b1;
                    if (fetch_valid) begin
                        capture_s    = 1'b1;
                        next_state_s = ST_FULL;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end else begin
                    next_state_s = ST_SECOND;
                end
            end
            default: begin
                next_state_s = ST_EMPTY;
            end
        endcase
        // A branch redirect kills everything presented this cycle.
        if (flush) begin
            next_state_s  = ST_EMPTY;
            capture_s     = 1'b0;
            pair_inc_s    = 1'b0;
            single_inc_s  = 1'b0;
            fetch_ready_s = 1'b0;
            slot0_valid_s = 1'b0;
            slot0_ins_s   = NOP;
            slot1_valid_s = 1'b0;
            slot1_ins_s   = NOP;
            pc_adv_s      = 2'd0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State and instruction buffer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_EMPTY;
            buf1_r   <= 32'd0;
            buf2_r   <= 32'd0;
            buf_ok_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (capture_s) begin
                buf1_r   <= fetch_ins1;
                buf2_r   <= fetch_ins2;
                buf_ok_r <= pair_ok;
            end
        end
    end

    // Wrapping issue performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_cnt_r   <= {CNT_W{1'b0}};
            single_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pair_inc_s) begin
                pair_cnt_r <= pair_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (single_inc_s) begin
                single_cnt_r <= single_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fetch_ready = fetch_ready_s;
    assign slot0_valid = slot0_valid_s;
    assign slot0_ins   = slot0_ins_s;
    assign slot1_valid = slot1_valid_s;
    assign slot1_ins   = slot1_ins_s;
    assign pc_adv      = pc_adv_s;
    assign pair_cnt    = pair_cnt_r;
    assign single_cnt  = single_cnt_r;

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// Scoreboard bench for dual_issue_sequencer: stimulus pushes expected issue
// records, a negedge monitor pops and compares whenever pc_adv is non-zero.
module tb_dual_issue_sequencer;

    localparam int          CNT_W = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk;
    logic             reset;
    logic             fetch_valid;
    logic [31:0]      fetch_ins1;
    logic [31:0]      fetch_ins2;
    logic             pair_ok;
    logic             issue_ready;
    logic             flush;
    logic             fetch_ready;
    logic             slot0_valid;
    logic [31:0]      slot0_ins;
    logic             slot1_valid;
    logic [31:0]      slot1_ins;
    logic [1:0]       pc_adv;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] single_cnt;

    typedef struct packed {
        logic [31:0] s0;
        logic        s1v;
        logic [31:0] s1;
        logic [1:0]  adv;
    } issue_t;

    issue_t sb[$];
    int     checks   = 0;
    int     failures = 0;
    int     exp_pair = 0;
    int     exp_single = 0;
    logic [31:0] held_s;

    dual_issue_sequencer #(.CNT_W(CNT_W), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
        .fetch_ins1(fetch_ins1), .fetch_ins2(fetch_ins2), .pair_ok(pair_ok),
        .issue_ready(issue_ready), .flush(flush), .fetch_ready(fetch_ready),
        .slot0_valid(slot0_valid), .slot0_ins(slot0_ins),
        .slot1_valid(slot1_valid), .slot1_ins(slot1_ins), .pc_adv(pc_adv),
        .pair_cnt(pair_cnt), .single_cnt(single_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and record the issue(s) it must produce.
    task automatic send(input logic [31:0] i1, input logic [31:0] i2, input logic ok);
        fetch_valid = 1'b1;
        fetch_ins1  = i1;
        fetch_ins2  = i2;
        pair_ok     = ok;
        if (ok) begin
            sb.push_back('{s0: i1, s1v: 1'b1, s1: i2, adv: 2'd2});
            exp_pair++;
        end else begin
            sb.push_back('{s0: i1, s1v: 1'b0, s1: NOP, adv: 2'd1});
            sb.push_back('{s0: i2, s1v: 1'b0, s1: NOP, adv: 2'd1});
            exp_single += 2;
        end
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pair_cnt"}, 32'(pair_cnt), 32'(exp_pair));
        chk({tag, "_single_cnt"}, 32'(single_cnt), 32'(exp_single));
    endtask

    // Monitor: every retiring cycle must match the oldest expected record.
    always @(negedge clk) begin
        if (pc_adv != 2'd0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual pc_adv=%0d slot0=%h expected no issue", pc_adv, slot0_ins);
            end else begin
                issue_t e;
                e = sb.pop_front();
                chk("mon_pc_adv", 32'(pc_adv), 32'(e.adv));
                chk("mon_slot0_valid", 32'(slot0_valid), 32'd1);
                chk("mon_slot0_ins", slot0_ins, e.s0);
                chk("mon_slot1_valid", 32'(slot1_valid), 32'(e.s1v));
                chk("mon_slot1_ins", slot1_ins, e.s1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_ins1 = 32'd0; fetch_ins2 = 32'd0;
        pair_ok = 1'b0; issue_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slot0_valid", 32'(slot0_valid), 32'd0);
        chk("rst_slot0_ins", slot0_ins, NOP);
        chk("rst_slot1_ins", slot1_ins, NOP);
        chk("rst_pc_adv", 32'(pc_adv), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk_cnts("rst");
        reset = 1'b0;

        // Legal pair issues together one cycle after capture.
        send(32'h00940333, 32'h409903B3, 1'b1);
        step();
        fetch_valid = 1'b0;
        chk("dual_pc_adv", 32'(pc_adv), 32'd2);
        step();
        chk_cnts("dual");

        // Illegal pair splits over two cycles.
        send(32'h00940333, 32'h409903B3, 1'b0);
        step();
        fetch_valid = 1'b0;
        chk("split1_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("split1_slot1_valid", 32'(slot1_valid), 32'd0);
        step();
        chk("split2_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("split2_slot0_ins", slot0_ins, 32'h409903B3);
        step();
        chk_cnts("split");

        // Five back-to-back pairs must issue without a bubble.
        for (int i = 0; i < 5; i++) begin
            send(32'h10000000 + 32'(i), 32'h20000000 + 32'(i), 1'b1);
            step();
            if (i > 0) begin
                chk("stream_pc_adv", 32'(pc_adv), 32'd2);
                chk("stream_fetch_ready", 32'(fetch_ready), 32'd1);
            end
        end
        fetch_valid = 1'b0;
        chk("stream_last_pc_adv", 32'(pc_adv), 32'd2);
        step();
        chk_cnts("stream");

        // Execute backpressure holds the buffered pair.
        issue_ready = 1'b0;
        send(32'h00A00513, 32'h00B00593, 1'b1);
        step();
        fetch_valid = 1'b0;
        held_s = 32'h00A00513;
        for (int i = 0; i < 3; i++) begin
            chk("stall_slot0_ins", slot0_ins, held_s);
            chk("stall_pc_adv", 32'(pc_adv), 32'd0);
            chk("stall_fetch_ready", 32'(fetch_ready), 32'd0);
            step();
        end
        issue_ready = 1'b1;
        #1;
        chk("stall_release_pc_adv", 32'(pc_adv), 32'd2);
        step();
        chk_cnts("stall");

        // Flush while the second half of a split pair is pending.
        send(32'h00C00613, 32'h00D00693, 1'b0);
        void'(sb.pop_back());
        exp_single--;
        step();
        fetch_valid = 1'b0;
        step();
        flush = 1'b1;
        #1;
        chk("flush_slot0_valid", 32'(slot0_valid), 32'd0);
        chk("flush_pc_adv", 32'(pc_adv), 32'd0);
        chk("flush_fetch_ready", 32'(fetch_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("post_flush_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("post_flush_slot0_valid", 32'(slot0_valid), 32'd0);
        chk_cnts("flush");

        // Asynchronous reset while FULL drops everything at once.
        issue_ready = 1'b0;
        send(32'h00E00713, 32'h00F00793, 1'b1);
        void'(sb.pop_back());
        exp_pair = 0;
        exp_single = 0;
        step();
        fetch_valid = 1'b0;
        chk("pre_areset_slot0_valid", 32'(slot0_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_slot0_valid", 32'(slot0_valid), 32'd0);
        chk("areset_slot0_ins", slot0_ins, NOP);
        chk("areset_slot1_valid", 32'(slot1_valid), 32'd0);
        chk("areset_pc_adv", 32'(pc_adv), 32'd0);
        chk_cnts("areset");
        step();
        reset = 1'b0;
        issue_ready = 1'b1;

        send(32'h00100093, 32'h00200113, 1'b1);
        step();
        fetch_valid = 1'b0;
        step();
        chk_cnts("recover");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
